fifo_uart_tx: RTL and testbench

FIFO_UART_TX -- requirements
Module: fifo_uart_tx

---
 rtl/fifo_uart_tx.sv | 120 ++++++++++++
 tb/tb_fifo_uart_tx.sv | 313 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fifo_uart_tx.sv
// UART transmitter that pulls bytes from an upstream FIFO and sends 8N1 frames.
// State, serial line and status outputs are all registered.
//
// state | meaning
// IDLE  | line high, issue FIFO read when enabled and data available
// LOAD  | one cycle, capture FIFO read data into the shift register
// START | start bit, line low for one bit period
// DATA  | eight data bits, LSB first
// STOP  | stop bit, line high, frame_done on its last cycle
module fifo_uart_tx #(
    parameter int CLKS_PER_BIT = 868,
    parameter int CNT_W        = 16
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       tx_en,
    input  logic       fifo_empty,
    input  logic [7:0] fifo_data,
    output logic       fifo_rd_en,
    output logic       tx,
    output logic       busy,
    output logic       frame_done
);

    localparam logic [CNT_W-1:0] CNT_LAST   = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [CNT_W-1:0] CNT_PENULT = CNT_W'(CLKS_PER_BIT - 2);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        LOAD  = 3'd1,
        START = 3'd2,
        DATA  = 3'd3,
        STOP  = 3'd4
    } state_t;

    state_t           state;
    logic [CNT_W-1:0] cnt;
    logic [2:0]       bit_idx;
    logic [7:0]       shreg;
    logic             rst_seen;
    logic             bit_end;

    assign bit_end = (cnt == CNT_LAST);

    // rst_seen holds off reads until the first clock edge after reset release
    assign fifo_rd_en = (state == IDLE) && rst_seen && tx_en && !fifo_empty;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= IDLE;
            tx         <= 1'b1;
            busy       <= 1'b0;
            frame_done <= 1'b0;
            cnt        <= '0;
            bit_idx    <= '0;
            shreg      <= '0;
            rst_seen   <= 1'b0;
        end else begin
            rst_seen   <= 1'b1;
            frame_done <= 1'b0;
            case (state)
                IDLE: begin
                    if (fifo_rd_en) begin
                        state <= LOAD;
                        busy  <= 1'b1;
                    end
                end
                LOAD: begin
                    shreg <= fifo_data;
                    cnt   <= '0;
                    tx    <= 1'b0;
                    state <= START;
                end
                START: begin
                    if (bit_end) begin
                        cnt     <= '0;
                        bit_idx <= '0;
                        tx      <= shreg[0];
                        state   <= DATA;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                DATA: begin
                    if (bit_end) begin
                        cnt <= '0;
                        if (bit_idx == 3'd7) begin
                            tx    <= 1'b1;
                            state <= STOP;
                        end else begin
                            // shreg[1] is the next bit before the shift lands
                            bit_idx <= bit_idx + 3'd1;
                            shreg   <= {1'b0, shreg[7:1]};
                            tx      <= shreg[1];
                        end
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                STOP: begin
                    if (bit_end) begin
                        cnt   <= '0;
                        busy  <= 1'b0;
                        state <= IDLE;
                    end else begin
                        cnt        <= cnt + 1'b1;
                        frame_done <= (cnt == CNT_PENULT);
                    end
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                    tx    <= 1'b1;
                    cnt   <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_fifo_uart_tx.sv
// Bench for fifo_uart_tx: table of known frames, hand-written corner sequences,
// and randomized traffic checked every cycle against a frame-level reference model.
module tb_fifo_uart_tx;

    localparam int N     = 4;
    localparam int CW    = 8;
    localparam int FRAME = 10 * N;

    logic       clk        = 1'b0;
    logic       rst        = 1'b0;
    logic       tx_en      = 1'b0;
    logic       fifo_empty = 1'b1;
    logic [7:0] fifo_data  = 8'h00;
    logic       fifo_rd_en;
    logic       tx;
    logic       busy;
    logic       frame_done;

    int vectors     = 0;
    int miscompares = 0;
    int cyc         = 0;

    // FIFO contents: bench pushes at wr_ptr, FIFO model pops at rd_ptr
    logic [7:0] src [512];
    int         wr_ptr = 0;
    int         rd_ptr = 0;
    int         pend_at = -10;

    typedef struct {
        logic [7:0] data;
        logic [9:0] frame;
        int         busy_len;
        int         fall_off;
        int         done_off;
    } vec_t;

    vec_t vt [7];

    fifo_uart_tx #(.CLKS_PER_BIT(N), .CNT_W(CW)) dut (
        .clk        (clk),
        .rst        (rst),
        .tx_en      (tx_en),
        .fifo_empty (fifo_empty),
        .fifo_data  (fifo_data),
        .fifo_rd_en (fifo_rd_en),
        .tx         (tx),
        .busy       (busy),
        .frame_done (frame_done)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk1(input string name, input logic got, input logic want);
        vectors++;
        if (got !== want) begin
            miscompares++;
            $display("FAIL %s @%0t: got %b, want %b", name, $time, got, want);
        end
    endtask

    task automatic chki(input string name, input int got, input int want);
        vectors++;
        if (got != want) begin
            miscompares++;
            $display("FAIL %s @%0t: got %0d, want %0d", name, $time, got, want);
        end
    endtask

    // Upstream FIFO: read data appears the cycle after a read; otherwise garbage
    always @(posedge clk) begin
        #1;
        if (pend_at == cyc - 1 && rd_ptr < wr_ptr) begin
            fifo_data = src[rd_ptr];
            rd_ptr    = rd_ptr + 1;
        end else begin
            fifo_data = 8'($urandom);
        end
        fifo_empty = (rd_ptr == wr_ptr);
    end

    // Reference model: once a read is seen at cycle t0, the line is a pure
    // function of (cycle - t0) and the byte at the FIFO head.
    bit         act = 1'b0;
    int         t0 = 0;
    logic [7:0] mbyte = 8'h00;
    int         since_rst = 0;

    always @(negedge clk) begin
        int   off;
        int   idx;
        logic e_tx;
        logic e_rd;
        if (!rst) begin
            act       = 1'b0;
            since_rst = 0;
            pend_at   = -10;
            chk1("rst_tx", tx, 1'b1);
            chk1("rst_busy", busy, 1'b0);
            chk1("rst_done", frame_done, 1'b0);
            chk1("rst_rd_en", fifo_rd_en, 1'b0);
        end else begin
            since_rst++;
            if (act && (cyc - t0) > FRAME + 1) act = 1'b0;
            if (act) begin
                off = cyc - t0;
                if (off < 2) e_tx = 1'b1;
                else begin
                    idx = (off - 2) / N;
                    if (idx == 0)      e_tx = 1'b0;
                    else if (idx == 9) e_tx = 1'b1;
                    else               e_tx = mbyte[idx-1];
                end
                chk1("model_tx", tx, e_tx);
                chk1("model_busy", busy, 1'b1);
                chk1("model_done", frame_done, off == FRAME + 1);
                chk1("model_rd_in_frame", fifo_rd_en, 1'b0);
            end else begin
                e_rd = tx_en && !fifo_empty;
                chk1("model_idle_tx", tx, 1'b1);
                chk1("model_idle_busy", busy, 1'b0);
                chk1("model_idle_done", frame_done, 1'b0);
                if (since_rst > 1 || fifo_rd_en) chk1("model_rd_en", fifo_rd_en, e_rd);
                if (fifo_rd_en) begin
                    act     = 1'b1;
                    t0      = cyc;
                    mbyte   = (rd_ptr < wr_ptr) ? src[rd_ptr] : 8'h00;
                    pend_at = cyc;
                end
            end
        end
    end

    task automatic push(input logic [7:0] b);
        src[wr_ptr] = b;
        wr_ptr      = wr_ptr + 1;
    endtask

    task automatic wait_rd(input int lim, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < lim; i++) begin
            @(negedge clk);
            if (fifo_rd_en) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) chk1("rd_en_timeout", fifo_rd_en, 1'b1);
    endtask

    task automatic run_frame(input vec_t v);
        int busy_n  = 0;
        int done_n  = 0;
        int done_at = -1;
        int fall_at = -1;
        bit ok;
        @(posedge clk); #2;
        push(v.data);
        wait_rd(20, ok);
        if (ok) begin
            for (int off = 1; off <= FRAME + 4; off++) begin
                @(negedge clk);
                if (busy) busy_n++;
                if (frame_done) begin
                    done_n++;
                    done_at = off;
                end
                if (!tx && fall_at < 0) fall_at = off;
                if (off >= 2 && off <= FRAME + 1)
                    chk1($sformatf("vec_%02h_bit", v.data), tx, v.frame[(off-2)/N]);
            end
            chki($sformatf("vec_%02h_busy_len", v.data), busy_n, v.busy_len);
            chki($sformatf("vec_%02h_done_cnt", v.data), done_n, 1);
            chki($sformatf("vec_%02h_done_off", v.data), done_at, v.done_off);
            chki($sformatf("vec_%02h_fall_off", v.data), fall_at, v.fall_off);
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, vectors %0d", vectors);
        $fatal(1, "watchdog");
    end

    initial begin
        int  rd_n;
        int  low_n;
        int  busy_n;
        int  done_n;
        int  last_done;
        bit  ok;
        int  nb;
        int  len;

        // frame bit i = i-th bit on the line: start, d0..d7, stop
        vt[0] = '{8'hA5, 10'b1101001010, 41, 2, 41};
        vt[1] = '{8'h00, 10'b1000000000, 41, 2, 41};
        vt[2] = '{8'hFF, 10'b1111111110, 41, 2, 41};
        vt[3] = '{8'h55, 10'b1010101010, 41, 2, 41};
        vt[4] = '{8'h3C, 10'b1001111000, 41, 2, 41};
        vt[5] = '{8'h01, 10'b1000000010, 41, 2, 41};
        vt[6] = '{8'h80, 10'b1100000000, 41, 2, 41};

        rst   = 1'b0;
        tx_en = 1'b0;
        repeat (4) @(posedge clk);
        #2;
        rst   = 1'b1;
        tx_en = 1'b1;

        for (int i = 0; i < 7; i++) run_frame(vt[i]);

        // empty FIFO, enabled
        rd_n = 0; low_n = 0; busy_n = 0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (fifo_rd_en) rd_n++;
            if (!tx) low_n++;
            if (busy) busy_n++;
        end
        chki("empty_rd_cnt", rd_n, 0);
        chki("empty_tx_low", low_n, 0);
        chki("empty_busy", busy_n, 0);

        // burst of three bytes
        @(posedge clk); #2;
        push(8'h00); push(8'hFF); push(8'h55);
        rd_n = 0; done_n = 0; last_done = -1;
        for (int i = 0; i < 200 && done_n < 3; i++) begin
            @(negedge clk);
            if (fifo_rd_en) begin
                rd_n++;
                if (last_done >= 0) chki("burst_gap", i - last_done, 1);
            end
            if (frame_done) begin
                done_n++;
                last_done = i;
            end
        end
        chki("burst_rd_cnt", rd_n, 3);
        chki("burst_done_cnt", done_n, 3);

        // tx_en dropped during data bit 3
        @(posedge clk); #2;
        push(8'h3C); push(8'h77);
        wait_rd(20, ok);
        if (ok) begin
            repeat (18) @(negedge clk);
            @(posedge clk); #2;
            tx_en = 1'b0;
            rd_n = 0;
            for (int i = 0; i < 80; i++) begin
                @(negedge clk);
                if (fifo_rd_en) rd_n++;
            end
            chki("txen_off_rd_cnt", rd_n, 0);
            chki("txen_off_fifo_left", wr_ptr - rd_ptr, 1);
        end
        @(posedge clk); #2;
        tx_en = 1'b1;
        wait_rd(10, ok);
        repeat (FRAME + 2) @(negedge clk);

        // reset during data bit 5
        @(posedge clk); #2;
        push(8'h96);
        wait_rd(20, ok);
        if (ok) begin
            repeat (25) @(negedge clk);
            @(posedge clk); #2;
            rst = 1'b0;
            #1;
            chk1("midrst_tx", tx, 1'b1);
            chk1("midrst_busy", busy, 1'b0);
            push(8'h5A);
            repeat (2) @(posedge clk);
            #2;
            rst = 1'b1;
            wait_rd(10, ok);
            done_n = 0;
            for (int i = 0; i < FRAME + 4; i++) begin
                @(negedge clk);
                if (frame_done) done_n++;
            end
            chki("midrst_new_frame_done", done_n, 1);
        end

        // randomized traffic with tx_en toggling
        for (int r = 0; r < 8; r++) begin
            @(posedge clk); #2;
            nb = $urandom_range(1, 3);
            for (int b = 0; b < nb; b++) push(8'($urandom));
            len = $urandom_range(20, 150);
            for (int c = 0; c < len; c++) begin
                @(posedge clk); #2;
                if (c % 10 == 0) tx_en = 1'($urandom_range(0, 1));
            end
        end
        @(posedge clk); #2;
        tx_en = 1'b1;
        for (int i = 0; i < 400; i++) begin
            @(negedge clk);
            if (rd_ptr == wr_ptr && !busy && !fifo_rd_en) break;
        end
        chki("random_drain_left", wr_ptr - rd_ptr, 0);

        repeat (3) @(negedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
